ps2_key_encoder: RTL and testbench
==================================

# ps2_key_encoder

Converts a raw PS/2 keyboard serial stream (device clock/data lines) into the 11-bit toggle-strobed `ps2_key` word the core's keyboard decoding logic consumes. It is the producing end of the `ps2_key` interface: frame reception, scancode prefix handling (E0 extended, F0 break, E1 pause) and strobe generation. It runs in the `clk_sys` domain.

## Interface
Parameters:
- `FILT_LEN`, 4: number of consecutive equal synchronized samples required to accept a new `ps2_clk` level (range 2..15).
- `TIMEOUT_CYC`, 4800: `clk_sys` cycles without a filtered falling edge mid-frame before the frame is abandoned (16-bit counter).

Ports:
- `clk_sys` in 1: system clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: PS/2 device clock, asynchronous to `clk_sys`.
- `ps2_data` in 1: PS/2 device data, asynchronous to `clk_sys`.
- `ps2_key` out 11: bit 10 is the toggle strobe, bit 9 is pressed (1 = make, 0 = break), bit 8 is extended (E0), bits 7:0 are the scancode.
- `frame_err` out 1: one-cycle pulse on a framing, parity or timeout error.

## Operation
- Synchronization: `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - Filtered clock `fclk` resets to 1.
  - `fclk` changes only after `FILT_LEN` consecutive synchronized samples differ from it.
  - A filtered falling edge (`fclk` going 1→0) samples synchronized data.
- Receiver FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: falling edge with data=0 goes to DATA with bit count 0. Data=1 is ignored.
  - DATA: shift LSB first; after the 8th bit go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: data=1 with parity OK raises `byte_valid` for one cycle. Otherwise `frame_err` pulses. Both cases return to IDLE.
- Parity: odd parity over the 8 data bits plus the parity bit.
- Timeout: a counter clears on every filtered falling edge.
  - In any state other than IDLE, reaching `TIMEOUT_CYC` forces IDLE and pulses `frame_err`.
  - The counter saturates and is inactive in IDLE.
- Prefix FSM, acting on each `byte_valid`:
  - E0: set `ext`.
  - F0: set `brk`.
  - E1: load a skip counter with 7. While the skip counter is nonzero, each byte decrements it and is discarded. Flags are cleared.
  - FA, AA, EE, FE, 00, FF: discarded; `ext` and `brk` cleared.
  - Any other byte: `ps2_key <= {~ps2_key[10], ~brk, ext, byte}`; `ext` and `brk` cleared.
- A frame error or timeout clears `ext`, `brk` and the skip counter, so no stale prefix is carried across a corrupt frame.
- Reset values: `ps2_key`=0, `frame_err`=0, `ext`=`brk`=0, skip counter=0, receiver in IDLE, filtered clock=1.

## Timing
- `byte_valid` is asserted in the cycle after the filtered falling edge of the stop bit.
- `ps2_key` updates on the following clock edge, i.e. 2 cycles after the filtered edge.
- Filtered-edge latency from the pin is 2 (synchronizer) + `FILT_LEN` cycles.
- `frame_err` is high for exactly one cycle, in the same cycle `byte_valid` would have been asserted.
- Bit 10 toggles exactly once per emitted key event. Consumers detect an event by comparing bit 10 with its previous value.
- Reset asserted mid-frame: all state returns to reset values immediately. Bits arriving after release are treated as a new frame: start bit required.
- The prefix FSM processes at most one byte per cycle. A PS/2 byte takes ≥ 60 µs, so no buffering is required.

## Configuration
- `PS2_KEY_PARITY_CHK_EN`:
  - Defined: a parity mismatch in STOP rejects the byte and pulses `frame_err`.
  - Undefined: the parity bit is received and ignored; only the stop-bit and timeout errors remain.

## Test plan
- Frame 0x1C (A key), valid parity and stop → `ps2_key` = {1, 1, 0, 0x1C}, toggle goes 0→1, `frame_err`=0.
- Bytes E0, F0, 0x75 (up-arrow release) → a single event `ps2_key[9:0]` = {0, 1, 0x75}, toggle flips once; E0 and F0 alone produce no toggle.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 0x29 → no event for the 8 pause bytes; 0x29 yields {1, 0, 0x29}.
- Frame 0x29 with a flipped parity bit:
  - with `PS2_KEY_PARITY_CHK_EN` → `frame_err` pulses once and `ps2_key` is unchanged;
  - without it → the event {1, 0, 0x29} is emitted.
- Stop clocking after 4 data bits for `TIMEOUT_CYC`+10 cycles → `frame_err` pulses once, the receiver returns to IDLE, and the next full 0x16 frame decodes correctly.
- 1-cycle glitches on `ps2_clk` shorter than `FILT_LEN` during a 0x05 frame → decoded as 0x05 with no error; `RESET_N` low mid-frame → `ps2_key`=0 and the next frame decodes cleanly.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard stream to toggle-strobed 11-bit ps2_key word (clk_sys domain).
// Optional macro PS2_KEY_PARITY_CHK_EN: reject bytes whose odd parity fails.
module ps2_key_encoder #(
   parameter int unsigned FILT_LEN    = 4,
   parameter int unsigned TIMEOUT_CYC = 4800
) (
   input  logic        clk_sys,
   input  logic        RESET_N,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int unsigned FCW = 4;
   localparam int unsigned TW  = 16;
   localparam int unsigned BCW = 3;
   localparam int unsigned SKW = 3;

`ifdef PS2_KEY_PARITY_CHK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]     clk_sync, data_sync;
   logic           clk_s, data_s;
   logic           fclk;
   logic [FCW-1:0] filt_cnt;
   logic           fall;
   logic           data_smp;

   state_t         state, state_n;
   logic [7:0]     shreg, shreg_n;
   logic [BCW-1:0] bit_cnt, bit_cnt_n;
   logic           par_bit, par_bit_n;
   logic           byte_valid, byte_valid_n;
   logic           frame_err_n;
   logic [TW-1:0]  tmo_cnt;
   logic           tmo_hit;
   logic           par_ok;

   logic           ext, brk;
   logic [SKW-1:0] skip;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   // Two-stage synchronizers; idle bus level is high.
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Glitch filter: fclk follows only after FILT_LEN consecutive differing samples.
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         fclk     <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
         data_smp <= 1'b1;
      end else begin
         fall     <= fclk & ~clk_s & (filt_cnt == FCW'(FILT_LEN - 1));
         data_smp <= data_s;
         if (clk_s != fclk) begin
            if (filt_cnt == FCW'(FILT_LEN - 1)) begin
               fclk     <= clk_s;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FCW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   // Mid-frame watchdog; cleared by every filtered falling edge, idle in IDLE.
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         tmo_cnt <= '0;
      end else if (state == IDLE || fall) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TW'(TIMEOUT_CYC)) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC));
   assign par_ok  = (^{shreg, par_bit}) || !PAR_CHK;

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         par_bit    <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_cnt    <= bit_cnt_n;
         par_bit    <= par_bit_n;
         byte_valid <= byte_valid_n;
         frame_err  <= frame_err_n;
      end
   end

   // Receiver next-state: start, 8 data bits LSB first, parity, stop.
   always_comb begin
      state_n      = state;
      shreg_n      = shreg;
      bit_cnt_n    = bit_cnt;
      par_bit_n    = par_bit;
      byte_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      if (tmo_hit) begin
         state_n     = IDLE;
         frame_err_n = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!data_smp) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               shreg_n   = {data_smp, shreg[7:1]};
               bit_cnt_n = bit_cnt + BCW'(1);
               if (bit_cnt == BCW'(7)) state_n = PARITY;
            end
            PARITY: begin
               par_bit_n = data_smp;
               state_n   = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (data_smp && par_ok) byte_valid_n = 1'b1;
               else                    frame_err_n  = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Prefix handling and key-event generation.
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         ps2_key <= '0;
         ext     <= 1'b0;
         brk     <= 1'b0;
         skip    <= '0;
      end else if (frame_err) begin
         ext  <= 1'b0;
         brk  <= 1'b0;
         skip <= '0;
      end else if (byte_valid) begin
         if (skip != '0) begin
            skip <= skip - SKW'(1);
            ext  <= 1'b0;
            brk  <= 1'b0;
         end else begin
            case (shreg)
               8'hE0: ext <= 1'b1;
               8'hF0: brk <= 1'b1;
               8'hE1: begin
                  skip <= SKW'(7);
                  ext  <= 1'b0;
                  brk  <= 1'b0;
               end
               8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                  ext <= 1'b0;
                  brk <= 1'b0;
               end
               default: begin
                  ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
                  ext     <= 1'b0;
                  brk     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: make/break/extended, pause, parity, timeout, glitch, reset.
module tb_ps2_key_encoder;

   localparam int HALF = 20;
   localparam int GAP  = 30;
   localparam int TMO  = 4800;

   logic        clk_sys = 1'b0;
   logic        RESET_N = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;

   int          errors = 0;
   int          checks = 0;
   int          err_pulses = 0;
   int          err_base;
   logic        exp_tog;
   logic [10:0] exp_key;

   ps2_key_encoder #(.FILT_LEN(4), .TIMEOUT_CYC(TMO)) dut (
      .clk_sys   (clk_sys),
      .RESET_N   (RESET_N),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2_key   (ps2_key),
      .frame_err (frame_err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) if (frame_err) err_pulses <= err_pulses + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      @(negedge clk_sys);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive the first nbits bits of a frame; optional 1-cycle clock glitches in each phase.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
      logic [10:0] f;
      f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         if (glitch) begin
            tick(5); ps2_clk = 1'b0; tick(1); ps2_clk = 1'b1; tick(HALF - 6);
         end else begin
            tick(HALF);
         end
         ps2_clk = 1'b0;
         if (glitch) begin
            tick(8); ps2_clk = 1'b1; tick(1); ps2_clk = 1'b0; tick(HALF - 9);
         end else begin
            tick(HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tick(GAP);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 11, 1'b0);
   endtask

   initial begin
      exp_tog = 1'b0;
      tick(5);
      check("reset_key", 16'(ps2_key), 16'h0000);
      check("reset_err", 16'(frame_err), 16'h0000);
      RESET_N = 1'b1;
      tick(10);

      // Plain make code
      err_base = err_pulses;
      send_byte(8'h1C);
      exp_tog = ~exp_tog;
      exp_key = {exp_tog, 1'b1, 1'b0, 8'h1C};
      check("make_1c", 16'(ps2_key), 16'(exp_key));
      check("make_1c_noerr", 16'(err_pulses - err_base), 16'd0);

      // Extended break: prefixes alone emit nothing
      err_base = err_pulses;
      send_byte(8'hE0);
      check("e0_no_event", 16'(ps2_key), 16'(exp_key));
      send_byte(8'hF0);
      check("f0_no_event", 16'(ps2_key), 16'(exp_key));
      send_byte(8'h75);
      exp_tog = ~exp_tog;
      exp_key = {exp_tog, 1'b0, 1'b1, 8'h75};
      check("ext_break_75", 16'(ps2_key), 16'(exp_key));
      check("ext_break_noerr", 16'(err_pulses - err_base), 16'd0);

      // Pause sequence swallowed entirely
      send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
      send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
      check("pause_no_event", 16'(ps2_key), 16'(exp_key));
      send_byte(8'h29);
      exp_tog = ~exp_tog;
      exp_key = {exp_tog, 1'b1, 1'b0, 8'h29};
      check("after_pause_29", 16'(ps2_key), 16'(exp_key));

      // Corrupted parity
      err_base = err_pulses;
      send_frame(8'h29, 1'b1, 11, 1'b0);
`ifdef PS2_KEY_PARITY_CHK_EN
      check("badpar_key_held", 16'(ps2_key), 16'(exp_key));
      check("badpar_err_once", 16'(err_pulses - err_base), 16'd1);
`else
      exp_tog = ~exp_tog;
      exp_key = {exp_tog, 1'b1, 1'b0, 8'h29};
      check("badpar_ignored_key", 16'(ps2_key), 16'(exp_key));
      check("badpar_ignored_noerr", 16'(err_pulses - err_base), 16'd0);
`endif

      // Timeout after start + 4 data bits
      err_base = err_pulses;
      send_frame(8'h16, 1'b0, 5, 1'b0);
      tick(TMO + 10);
      check("timeout_err_once", 16'(err_pulses - err_base), 16'd1);
      check("timeout_key_held", 16'(ps2_key), 16'(exp_key));
      err_base = err_pulses;
      send_byte(8'h16);
      exp_tog = ~exp_tog;
      exp_key = {exp_tog, 1'b1, 1'b0, 8'h16};
      check("post_timeout_16", 16'(ps2_key), 16'(exp_key));
      check("post_timeout_noerr", 16'(err_pulses - err_base), 16'd0);

      // Short clock glitches rejected by the filter
      err_base = err_pulses;
      send_frame(8'h05, 1'b0, 11, 1'b1);
      exp_tog = ~exp_tog;
      exp_key = {exp_tog, 1'b1, 1'b0, 8'h05};
      check("glitch_05", 16'(ps2_key), 16'(exp_key));
      check("glitch_noerr", 16'(err_pulses - err_base), 16'd0);

      // Reset in the middle of a frame
      send_frame(8'h1C, 1'b0, 5, 1'b0);
      RESET_N = 1'b0;
      tick(3);
      check("midreset_key", 16'(ps2_key), 16'h0000);
      check("midreset_err", 16'(frame_err), 16'h0000);
      RESET_N = 1'b1;
      tick(10);
      exp_tog = 1'b0;
      err_base = err_pulses;
      send_byte(8'h1C);
      exp_tog = ~exp_tog;
      exp_key = {exp_tog, 1'b1, 1'b0, 8'h1C};
      check("post_reset_1c", 16'(ps2_key), 16'(exp_key));
      check("post_reset_noerr", 16'(err_pulses - err_base), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
